// File: rtl/uart_tx_frame_if.sv
// Handshake and line bundle for uart_tx_frame.
// Word source side drives i_TX_DV/i_TX_Word, the transmitter drives the o_* status and line.
// With UART_TX_PARITY_EN defined, the bundle also carries i_Parity_Mode.
interface uart_tx_frame_if #(
   parameter int DATA_BITS = 8
);
   logic                 i_TX_DV;
   logic [DATA_BITS-1:0] i_TX_Word;
`ifdef UART_TX_PARITY_EN
   logic [1:0]           i_Parity_Mode;
`endif
   logic                 o_TX_Ready;
   logic                 o_TX_Active;
   logic                 o_TX_Serial;
   logic                 o_TX_Done;

`ifdef UART_TX_PARITY_EN
   modport master (
      output i_TX_DV, i_TX_Word, i_Parity_Mode,
      input  o_TX_Ready, o_TX_Active, o_TX_Serial, o_TX_Done
   );

   modport slave (
      input  i_TX_DV, i_TX_Word, i_Parity_Mode,
      output o_TX_Ready, o_TX_Active, o_TX_Serial, o_TX_Done
   );
`else
   modport master (
      output i_TX_DV, i_TX_Word,
      input  o_TX_Ready, o_TX_Active, o_TX_Serial, o_TX_Done
   );

   modport slave (
      input  i_TX_DV, i_TX_Word,
      output o_TX_Ready, o_TX_Active, o_TX_Serial, o_TX_Done
   );
`endif
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop(1).
// Each serial bit lasts CLKS_PER_BIT clocks. A word is taken when i_TX_DV & o_TX_Ready.
// Optional feature macro: UART_TX_PARITY_EN adds i_Parity_Mode and the PARITY state
// (01 even, 10 odd, 00/11 no parity slot). Without the macro frames never carry parity.
module uart_tx_frame #(
   parameter int CLKS_PER_BIT = 217,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1
) (
   input logic            i_Clock,
   input logic            i_Rst_L,
   uart_tx_frame_if.slave tx
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd3,
      S_PARITY = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd3
   } state_t;
`endif

   state_t               state;
   logic [CNT_W-1:0]     clk_cnt;
   logic [IDX_W-1:0]     bit_idx;   // data bit index in DATA, stop bit index in STOP
   logic [IDX_W-1:0]     next_idx;
   logic [DATA_BITS-1:0] word_q;
   logic                 xfer;

`ifdef UART_TX_PARITY_EN
   logic par_on;    // this frame carries a parity slot
   logic par_bit;   // parity value computed when the word was taken
   logic par_req;

   assign par_req = (tx.i_Parity_Mode == 2'b01) || (tx.i_Parity_Mode == 2'b10);
`endif

   assign xfer     = tx.i_TX_DV && tx.o_TX_Ready && (state == S_IDLE);
   assign next_idx = bit_idx + IDX_W'(1);

   // Capture the word (and its parity) on transfer; payload needs no reset.
   always_ff @(posedge i_Clock) begin
      if (xfer) begin
         word_q <= tx.i_TX_Word;
`ifdef UART_TX_PARITY_EN
         par_bit <= (tx.i_Parity_Mode == 2'b10) ? ~^tx.i_TX_Word : ^tx.i_TX_Word;
`endif
      end
   end

   // Frame sequencer with registered line and status outputs.
   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state          <= S_IDLE;
         clk_cnt        <= '0;
         bit_idx        <= '0;
         tx.o_TX_Serial <= 1'b1;
         tx.o_TX_Ready  <= 1'b1;
         tx.o_TX_Active <= 1'b0;
         tx.o_TX_Done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_on         <= 1'b0;
`endif
      end else begin
         tx.o_TX_Done <= 1'b0;
         case (state)
            S_IDLE: begin
               clk_cnt        <= '0;
               bit_idx        <= '0;
               tx.o_TX_Serial <= 1'b1;
               if (xfer) begin
                  // Start bit appears on the line right after the transfer edge.
                  state          <= S_START;
                  tx.o_TX_Ready  <= 1'b0;
                  tx.o_TX_Active <= 1'b1;
                  tx.o_TX_Serial <= 1'b0;
`ifdef UART_TX_PARITY_EN
                  par_on         <= par_req;
`endif
               end else begin
                  tx.o_TX_Ready  <= 1'b1;
                  tx.o_TX_Active <= 1'b0;
               end
            end

            S_START: begin
               if (clk_cnt == CNT_LAST) begin
                  clk_cnt        <= '0;
                  state          <= S_DATA;
                  tx.o_TX_Serial <= word_q[0];
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end

            S_DATA: begin
               if (clk_cnt == CNT_LAST) begin
                  clk_cnt <= '0;
                  if (bit_idx == DATA_LAST) begin
                     bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                     if (par_on) begin
                        state          <= S_PARITY;
                        tx.o_TX_Serial <= par_bit;
                     end else begin
                        state          <= S_STOP;
                        tx.o_TX_Serial <= 1'b1;
                     end
`else
                     state          <= S_STOP;
                     tx.o_TX_Serial <= 1'b1;
`endif
                  end else begin
                     bit_idx        <= next_idx;
                     tx.o_TX_Serial <= word_q[next_idx];
                  end
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (clk_cnt == CNT_LAST) begin
                  clk_cnt        <= '0;
                  state          <= S_STOP;
                  tx.o_TX_Serial <= 1'b1;
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end
`endif

            S_STOP: begin
               if (clk_cnt == CNT_LAST) begin
                  clk_cnt <= '0;
                  if (bit_idx == STOP_LAST) begin
                     // Back to IDLE: Done/Ready show in the first idle cycle,
                     // so a waiting word leaves exactly one idle-high cycle.
                     bit_idx        <= '0;
                     state          <= S_IDLE;
                     tx.o_TX_Done   <= 1'b1;
                     tx.o_TX_Ready  <= 1'b1;
                     tx.o_TX_Active <= 1'b0;
                     tx.o_TX_Serial <= 1'b1;
                  end else begin
                     bit_idx <= next_idx;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end

            default: begin
               state          <= S_IDLE;
               clk_cnt        <= '0;
               bit_idx        <= '0;
               tx.o_TX_Serial <= 1'b1;
               tx.o_TX_Ready  <= 1'b1;
               tx.o_TX_Active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: scoreboard of expected frames checked by a line monitor,
// plus directed checks on a 5-bit / 2-stop instance (frame length, async reset).
module tb_uart_tx_frame;

   localparam int C = 4;
   localparam logic [31:0] BIT_ONES = 32'((1 << C) - 1);

   logic clk = 1'b0;
   logic rst_a_n;
   logic rst_b_n;

   always #5 clk = ~clk;

   uart_tx_frame_if #(.DATA_BITS(8)) ifa ();
   uart_tx_frame_if #(.DATA_BITS(5)) ifb ();

   uart_tx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(1)) dut_a (
      .i_Clock (clk),
      .i_Rst_L (rst_a_n),
      .tx      (ifa)
   );

   uart_tx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(5), .STOP_BITS(2)) dut_b (
      .i_Clock (clk),
      .i_Rst_L (rst_b_n),
      .tx      (ifb)
   );

   typedef struct packed {
      logic [7:0] word;
      logic       par_on;
      logic       par_bit;
   } exp_t;

   exp_t sb[$];
   int   nvec      = 0;
   int   nerr      = 0;
   int   n_sent_a  = 0;
   int   done_cnt_a = 0;
   logic mon_busy  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (ifa.o_TX_Done === 1'b1) done_cnt_a++;
   end

   // Push one word into dut_a; optionally leave i_TX_DV high afterwards.
   task automatic send_a(input logic [7:0] w, input logic [1:0] mode, input bit hold);
      int   t;
      exp_t e;
      bit   par_en;
`ifdef UART_TX_PARITY_EN
      par_en = 1'b1;
`else
      par_en = 1'b0;
`endif
      @(negedge clk);
      ifa.i_TX_DV   = 1'b1;
      ifa.i_TX_Word = w;
`ifdef UART_TX_PARITY_EN
      ifa.i_Parity_Mode = mode;
`endif
      t = 0;
      while (ifa.o_TX_Ready !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk("a_ready_timeout", 32'd0, 32'd1);
      e.word    = w;
      e.par_on  = par_en && (mode == 2'b01 || mode == 2'b10);
      e.par_bit = (mode == 2'b01) ? ^w : ~^w;
      sb.push_back(e);
      n_sent_a++;
      @(posedge clk);
      #1;
      if (!hold) ifa.i_TX_DV = 1'b0;
   endtask

   task automatic drain_a(input string tag);
      int t = 0;
      while ((sb.size() != 0 || mon_busy || ifa.o_TX_Ready !== 1'b1) && t < 1000) begin
         @(negedge clk);
         t++;
      end
      chk(tag, (t < 1000) ? 32'd1 : 32'd0, 32'd1);
      repeat (3) @(negedge clk);
   endtask

   // Line monitor for dut_a: pops the expected frame at each start bit.
   initial begin : mon_a
      exp_t        e;
      logic        bits [0:11];
      int          nb;
      int          bad_ctl;
      logic [31:0] obs;
      forever begin
         @(negedge clk);
         if (rst_a_n === 1'b1 && ifa.o_TX_Serial === 1'b0) begin
            mon_busy = 1'b1;
            if (sb.size() == 0) begin
               chk("a_unexpected_frame", 32'd1, 32'd0);
               e = '0;
            end else begin
               e = sb.pop_front();
            end
            bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) bits[1 + i] = e.word[i];
            nb = 9;
            if (e.par_on) begin
               bits[nb] = e.par_bit;
               nb++;
            end
            bits[nb] = 1'b1;
            nb++;
            bad_ctl = 0;
            for (int b = 0; b < nb; b++) begin
               obs = '0;
               for (int k = 0; k < C; k++) begin
                  if (b != 0 || k != 0) @(negedge clk);
                  obs[k] = ifa.o_TX_Serial;
                  if (ifa.o_TX_Active !== 1'b1 || ifa.o_TX_Done !== 1'b0 || ifa.o_TX_Ready !== 1'b0)
                     bad_ctl++;
               end
               chk($sformatf("a_w%02h_bit%0d", e.word, b), obs, bits[b] ? BIT_ONES : 32'd0);
            end
            chk($sformatf("a_w%02h_ctl_in_frame", e.word), bad_ctl, 0);
            @(negedge clk);
            chk($sformatf("a_w%02h_done", e.word), ifa.o_TX_Done, 1'b1);
            chk($sformatf("a_w%02h_ready", e.word), ifa.o_TX_Ready, 1'b1);
            chk($sformatf("a_w%02h_active", e.word), ifa.o_TX_Active, 1'b0);
            chk($sformatf("a_w%02h_idle_line", e.word), ifa.o_TX_Serial, 1'b1);
            mon_busy = 1'b0;
         end
      end
   end

   task automatic send_b(input logic [4:0] w);
      int t = 0;
      @(negedge clk);
      ifb.i_TX_DV   = 1'b1;
      ifb.i_TX_Word = w;
      while (ifb.o_TX_Ready !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk("b_ready_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      ifb.i_TX_DV = 1'b0;
   endtask

   // Sample 32 line cycles of a dut_b frame; sample i lands in bit i.
   task automatic frame_b(input logic [4:0] w, input logic [31:0] exp_vec, input string tag);
      logic [31:0] v;
      int          dn;
      send_b(w);
      v  = '0;
      dn = 0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         v[i] = ifb.o_TX_Serial;
         if (ifb.o_TX_Done === 1'b1) dn++;
      end
      chk({tag, "_line"}, v, exp_vec);
      chk({tag, "_done_in_frame"}, dn, 0);
      @(negedge clk);
      chk({tag, "_done_end"}, ifb.o_TX_Done, 1'b1);
      @(negedge clk);
      chk({tag, "_done_single"}, ifb.o_TX_Done, 1'b0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog timeout vectors=%0d", nvec);
      $fatal(1, "bench timeout");
   end

   initial begin : main
      int dn;
      int bad_line;
      rst_a_n       = 1'b0;
      rst_b_n       = 1'b0;
      ifa.i_TX_DV   = 1'b0;
      ifa.i_TX_Word = '0;
      ifb.i_TX_DV   = 1'b0;
      ifb.i_TX_Word = '0;
`ifdef UART_TX_PARITY_EN
      ifa.i_Parity_Mode = 2'b00;
      ifb.i_Parity_Mode = 2'b00;
`endif
      repeat (3) @(negedge clk);
      chk("rst_a_serial", ifa.o_TX_Serial, 1'b1);
      chk("rst_a_ready",  ifa.o_TX_Ready,  1'b1);
      chk("rst_a_active", ifa.o_TX_Active, 1'b0);
      chk("rst_a_done",   ifa.o_TX_Done,   1'b0);
      chk("rst_b_serial", ifb.o_TX_Serial, 1'b1);
      chk("rst_b_ready",  ifb.o_TX_Ready,  1'b1);
      rst_a_n = 1'b1;
      rst_b_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single frame 0xA5, no parity
      send_a(8'hA5, 2'b00, 1'b0);
      drain_a("a_drain_a5");

      // Back-to-back 0x00 then 0xFF with i_TX_DV held high
      send_a(8'h00, 2'b00, 1'b1);
      send_a(8'hFF, 2'b00, 1'b0);
      @(negedge clk);
      chk("a_b2b_start_after_one_idle", ifa.o_TX_Serial, 1'b0);
      drain_a("a_drain_b2b");

      // Stray i_TX_DV and word change while busy are ignored
      send_a(8'hC3, 2'b00, 1'b0);
      repeat (10) @(negedge clk);
      ifa.i_TX_DV   = 1'b1;
      ifa.i_TX_Word = 8'h55;
      @(negedge clk);
      ifa.i_TX_DV   = 1'b0;
      drain_a("a_drain_ignore");
      repeat (50) @(negedge clk);

`ifdef UART_TX_PARITY_EN
      send_a(8'h07, 2'b01, 1'b0);
      send_a(8'h07, 2'b10, 1'b0);
      send_a(8'h07, 2'b11, 1'b0);
      send_a(8'h07, 2'b00, 1'b0);
      drain_a("a_drain_parity");
`endif

      chk("a_done_count", done_cnt_a, n_sent_a);
      chk("a_sb_empty", sb.size(), 0);

      // 5 data bits, 2 stop bits: 32-clock frames, stop high for 8 clocks
      frame_b(5'h1F, 32'hFFFF_FFF0, "b_1f");
      frame_b(5'h00, 32'hFF00_0000, "b_00");

      // Asynchronous reset in the middle of a data bit
      send_b(5'h00);
      repeat (8) @(negedge clk);
      chk("b_pre_rst_line_low", ifb.o_TX_Serial, 1'b0);
      @(posedge clk);
      #2;
      rst_b_n = 1'b0;
      #1;
      chk("b_async_serial", ifb.o_TX_Serial, 1'b1);
      chk("b_async_ready",  ifb.o_TX_Ready,  1'b1);
      chk("b_async_active", ifb.o_TX_Active, 1'b0);
      chk("b_async_done",   ifb.o_TX_Done,   1'b0);
      repeat (2) @(negedge clk);
      rst_b_n = 1'b1;
      dn = 0;
      bad_line = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (ifb.o_TX_Done === 1'b1) dn++;
         if (ifb.o_TX_Serial !== 1'b1) bad_line++;
      end
      chk("b_abort_no_done", dn, 0);
      chk("b_abort_line_idle", bad_line, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
